fetch_addr_gen: RTL and testbench

- Fetch-side PC generator, directly upstream of branch_predictor: issues one search per fetch PC and consumes the valid/hit/predict/target response to choose the next PC.
- Emits one fetch request per PC to the instruction-fetch stage, carrying the prediction tag.
- Execute-stage jump resolution redirects the PC. Stalls on fetch backpressure. Tolerates variable predictor latency via a timeout.

---
 rtl/fetch_addr_gen_pkg.sv | 22 ++
 rtl/fetch_addr_gen_timer.sv | 30 +++
 rtl/fetch_addr_gen.sv | 175 +++++++++++++++++
 tb/tb_fetch_addr_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_addr_gen_pkg.sv
// Shared definitions for the fetch PC generator: FSM state encoding,
// instruction size and PC alignment helper.
package fetch_addr_gen_pkg;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_SEARCH     = 3'd1,
    S_WAIT       = 3'd2,
    S_REQ        = 3'd3,
    S_DRAIN      = 3'd4,
    S_DRAIN_LATE = 3'd5
  } state_t;

  localparam logic [31:0] INST_SIZE     = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Force a word-aligned PC.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_addr_gen_timer.sv
// Predictor search timeout counter: cleared while a search is issued,
// counts while a response is awaited, saturates once expired.
module fetch_addr_gen_timer #(
  parameter int unsigned P_TIMEOUT = 4
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iCLEAR,
  input  logic iENABLE,
  output logic oEXPIRED
);

  localparam logic [7:0] LIMIT = 8'(P_TIMEOUT);

  logic [7:0] count;

  assign oEXPIRED = (count >= LIMIT);

  // Count wait cycles; hold once the limit is reached.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      count <= '0;
    end else if (iCLEAR) begin
      count <= '0;
    end else if (iENABLE && !oEXPIRED) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/fetch_addr_gen.sv
// Fetch-side PC generator: searches the branch predictor once per PC,
// emits a fetch request carrying the prediction, and follows execute
// redirects. Optional performance counters under FETCH_ADDR_GEN_PERF_COUNTER_EN.
module fetch_addr_gen
  import fetch_addr_gen_pkg::*;
#(
  parameter logic [31:0] P_RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned P_SEARCH_TIMEOUT = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  output logic        oBP_SEARCH_STB,
  output logic [31:0] oBP_SEARCH_INST_ADDR,
  input  logic        iBP_SEARCH_VALID,
  input  logic        iBP_SEARCH_HIT,
  input  logic        iBP_SEARCH_PREDICT_BRANCH,
  input  logic [31:0] iBP_SEARCH_ADDR,
  input  logic        iJUMP_STB,
  input  logic [31:0] iJUMP_ADDR,
  output logic        oFETCH_REQ,
  output logic [31:0] oFETCH_ADDR,
  output logic        oFETCH_PREDICT,
  output logic [31:0] oFETCH_PREDICT_ADDR,
  input  logic        iFETCH_BUSY,
  output logic [31:0] oPERF_TAKEN_CNT,
  output logic [31:0] oPERF_REDIRECT_CNT
);

  state_t      state, stateNext;
  logic [31:0] pc, pcNext;
  logic        stbNext;
  logic [31:0] searchAddrNext;
  logic        reqNext;
  logic [31:0] fetchAddrNext;
  logic        predictNext;
  logic [31:0] predictAddrNext;
  logic        timerClear, timerEnable, timerExpired;
  logic        outstanding;

  fetch_addr_gen_timer #(
    .P_TIMEOUT(P_SEARCH_TIMEOUT)
  ) u_timer (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .iCLEAR  (timerClear),
    .iENABLE (timerEnable),
    .oEXPIRED(timerExpired)
  );

  // State register.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= S_INIT;
    else          state <= stateNext;
  end

  // Next-state, next-PC mux and next values of all registered outputs.
  always_comb begin
    stateNext       = state;
    pcNext          = pc;
    stbNext         = 1'b0;
    searchAddrNext  = oBP_SEARCH_INST_ADDR;
    reqNext         = oFETCH_REQ;
    fetchAddrNext   = oFETCH_ADDR;
    predictNext     = oFETCH_PREDICT;
    predictAddrNext = oFETCH_PREDICT_ADDR;
    timerClear      = 1'b0;
    timerEnable     = 1'b0;
    outstanding     = 1'b0;

    unique case (state)
      S_INIT: begin
        stateNext      = S_SEARCH;
        stbNext        = 1'b1;
        searchAddrNext = pc;
      end
      S_SEARCH: begin
        timerClear = 1'b1;
        stateNext  = S_WAIT;
      end
      S_WAIT: begin
        timerEnable = 1'b1;
        if (iBP_SEARCH_VALID) begin
          predictNext     = iBP_SEARCH_HIT && iBP_SEARCH_PREDICT_BRANCH;
          predictAddrNext = predictNext ? alignPc(iBP_SEARCH_ADDR) : '0;
          reqNext         = 1'b1;
          fetchAddrNext   = pc;
          stateNext       = S_REQ;
        end else if (timerExpired) begin
          predictNext     = 1'b0;
          predictAddrNext = '0;
          reqNext         = 1'b1;
          fetchAddrNext   = pc;
          stateNext       = S_DRAIN_LATE;
        end
      end
      S_REQ, S_DRAIN_LATE: begin
        if (!iFETCH_BUSY) begin
          pcNext         = oFETCH_PREDICT ? oFETCH_PREDICT_ADDR : pc + INST_SIZE;
          reqNext        = 1'b0;
          stbNext        = 1'b1;
          searchAddrNext = pcNext;
          stateNext      = S_SEARCH;
        end
      end
      S_DRAIN: begin
        timerEnable = 1'b1;
        if (iBP_SEARCH_VALID || timerExpired) begin
          stbNext        = 1'b1;
          searchAddrNext = pc;
          stateNext      = S_SEARCH;
        end
      end
      default: stateNext = S_INIT;
    endcase

    // Redirect overrides everything above; a search still unresolved after
    // this cycle must be drained before the jump target can be searched.
    if (iJUMP_STB && state != S_INIT) begin
      outstanding = (state == S_SEARCH) ||
                    ((state == S_WAIT || state == S_DRAIN) &&
                     !iBP_SEARCH_VALID && !timerExpired);
      pcNext  = alignPc(iJUMP_ADDR);
      reqNext = 1'b0;
      if (outstanding) begin
        stbNext   = 1'b0;
        stateNext = S_DRAIN;
      end else begin
        stbNext        = 1'b1;
        searchAddrNext = pcNext;
        stateNext      = S_SEARCH;
      end
    end
  end

  // Registered PC and outputs.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      pc                   <= P_RESET_VECTOR;
      oBP_SEARCH_STB       <= 1'b0;
      oBP_SEARCH_INST_ADDR <= P_RESET_VECTOR;
      oFETCH_REQ           <= 1'b0;
      oFETCH_ADDR          <= P_RESET_VECTOR;
      oFETCH_PREDICT       <= 1'b0;
      oFETCH_PREDICT_ADDR  <= '0;
    end else begin
      pc                   <= pcNext;
      oBP_SEARCH_STB       <= stbNext;
      oBP_SEARCH_INST_ADDR <= searchAddrNext;
      oFETCH_REQ           <= reqNext;
      oFETCH_ADDR          <= fetchAddrNext;
      oFETCH_PREDICT       <= predictNext;
      oFETCH_PREDICT_ADDR  <= predictAddrNext;
    end
  end

`ifdef FETCH_ADDR_GEN_PERF_COUNTER_EN
  logic accepted;
  assign accepted = (state == S_REQ || state == S_DRAIN_LATE) && !iFETCH_BUSY;

  // Wrapping counters of accepted taken predictions and redirect cycles.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oPERF_TAKEN_CNT    <= '0;
      oPERF_REDIRECT_CNT <= '0;
    end else begin
      if (accepted && oFETCH_PREDICT) oPERF_TAKEN_CNT <= oPERF_TAKEN_CNT + 32'd1;
      if (iJUMP_STB) oPERF_REDIRECT_CNT <= oPERF_REDIRECT_CNT + 32'd1;
    end
  end
`else
  assign oPERF_TAKEN_CNT    = '0;
  assign oPERF_REDIRECT_CNT = '0;
`endif

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Directed bench for fetch_addr_gen: sequential fetch, taken prediction,
// backpressure, search timeout, redirects, PC wrap and async reset.
module tb_fetch_addr_gen;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        oBP_SEARCH_STB;
  logic [31:0] oBP_SEARCH_INST_ADDR;
  logic        iBP_SEARCH_VALID = 1'b0;
  logic        iBP_SEARCH_HIT = 1'b0;
  logic        iBP_SEARCH_PREDICT_BRANCH = 1'b0;
  logic [31:0] iBP_SEARCH_ADDR = '0;
  logic        iJUMP_STB = 1'b0;
  logic [31:0] iJUMP_ADDR = '0;
  logic        oFETCH_REQ;
  logic [31:0] oFETCH_ADDR;
  logic        oFETCH_PREDICT;
  logic [31:0] oFETCH_PREDICT_ADDR;
  logic        iFETCH_BUSY = 1'b0;
  logic [31:0] oPERF_TAKEN_CNT;
  logic [31:0] oPERF_REDIRECT_CNT;

  int vectors = 0;
  int miscompares = 0;

  fetch_addr_gen #(
    .P_RESET_VECTOR  (32'h0000_0000),
    .P_SEARCH_TIMEOUT(4)
  ) dut (
    .iCLOCK                   (iCLOCK),
    .inRESET                  (inRESET),
    .oBP_SEARCH_STB           (oBP_SEARCH_STB),
    .oBP_SEARCH_INST_ADDR     (oBP_SEARCH_INST_ADDR),
    .iBP_SEARCH_VALID         (iBP_SEARCH_VALID),
    .iBP_SEARCH_HIT           (iBP_SEARCH_HIT),
    .iBP_SEARCH_PREDICT_BRANCH(iBP_SEARCH_PREDICT_BRANCH),
    .iBP_SEARCH_ADDR          (iBP_SEARCH_ADDR),
    .iJUMP_STB                (iJUMP_STB),
    .iJUMP_ADDR               (iJUMP_ADDR),
    .oFETCH_REQ               (oFETCH_REQ),
    .oFETCH_ADDR              (oFETCH_ADDR),
    .oFETCH_PREDICT           (oFETCH_PREDICT),
    .oFETCH_PREDICT_ADDR      (oFETCH_PREDICT_ADDR),
    .iFETCH_BUSY              (iFETCH_BUSY),
    .oPERF_TAKEN_CNT          (oPERF_TAKEN_CNT),
    .oPERF_REDIRECT_CNT       (oPERF_REDIRECT_CNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  // From a SEARCH cycle: check the strobe, answer one cycle later, land in REQ.
  task automatic toReq(input logic [31:0] pcExp, input logic hit, input logic pb,
                       input logic [31:0] tgt, input logic predExp,
                       input logic [31:0] paddrExp);
    chk("search_stb", oBP_SEARCH_STB, 1);
    chk("search_addr", oBP_SEARCH_INST_ADDR, pcExp);
    tick();
    chk("wait_stb", oBP_SEARCH_STB, 0);
    chk("wait_req", oFETCH_REQ, 0);
    iBP_SEARCH_VALID = 1'b1;
    iBP_SEARCH_HIT = hit;
    iBP_SEARCH_PREDICT_BRANCH = pb;
    iBP_SEARCH_ADDR = tgt;
    tick();
    iBP_SEARCH_VALID = 1'b0;
    iBP_SEARCH_HIT = 1'b0;
    iBP_SEARCH_PREDICT_BRANCH = 1'b0;
    iBP_SEARCH_ADDR = '0;
    chk("req", oFETCH_REQ, 1);
    chk("req_addr", oFETCH_ADDR, pcExp);
    chk("req_pred", oFETCH_PREDICT, predExp);
    chk("req_paddr", oFETCH_PREDICT_ADDR, paddrExp);
  endtask

  // Full fetch loop ending in the next SEARCH cycle.
  task automatic doSearch(input logic [31:0] pcExp, input logic hit, input logic pb,
                          input logic [31:0] tgt, input logic predExp,
                          input logic [31:0] paddrExp);
    toReq(pcExp, hit, pb, tgt, predExp, paddrExp);
    tick();
  endtask

  initial begin
    #2;
    chk("rst_stb", oBP_SEARCH_STB, 0);
    chk("rst_saddr", oBP_SEARCH_INST_ADDR, 32'h0);
    chk("rst_req", oFETCH_REQ, 0);
    chk("rst_faddr", oFETCH_ADDR, 32'h0);
    chk("rst_pred", oFETCH_PREDICT, 0);
    chk("rst_paddr", oFETCH_PREDICT_ADDR, 32'h0);
    #20 inRESET = 1'b1;
    tick();

    // Sequential misses: 0x0, 0x4, 0x8 at one request every 3 cycles.
    doSearch(32'h0, 0, 0, 32'h0, 0, 32'h0);
    doSearch(32'h4, 0, 0, 32'h0, 0, 32'h0);
    doSearch(32'h8, 0, 0, 32'h0, 0, 32'h0);

    // Redirect from REQ to 0x100, then a taken hit with unaligned target.
    toReq(32'hC, 0, 0, 32'h0, 0, 32'h0);
    iJUMP_STB = 1'b1;
    iJUMP_ADDR = 32'h100;
    tick();
    iJUMP_STB = 1'b0;
    chk("jmp_req_drop", oFETCH_REQ, 0);
    doSearch(32'h100, 1, 1, 32'h2003, 1, 32'h2000);

    // Backpressure: request held five cycles, no new strobe.
    toReq(32'h2000, 0, 0, 32'h0, 0, 32'h0);
    iFETCH_BUSY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("busy_req", oFETCH_REQ, 1);
      chk("busy_addr", oFETCH_ADDR, 32'h2000);
      chk("busy_stb", oBP_SEARCH_STB, 0);
      tick();
    end
    iFETCH_BUSY = 1'b0;
    chk("busy_end_req", oFETCH_REQ, 1);
    tick();

    // Silent predictor: five WAIT cycles (count 0..4), then miss request.
    chk("to_stb", oBP_SEARCH_STB, 1);
    chk("to_saddr", oBP_SEARCH_INST_ADDR, 32'h2004);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("to_wait_req", oFETCH_REQ, 0);
      chk("to_wait_stb", oBP_SEARCH_STB, 0);
    end
    tick();
    chk("to_req", oFETCH_REQ, 1);
    chk("to_addr", oFETCH_ADDR, 32'h2004);
    chk("to_pred", oFETCH_PREDICT, 0);
    iFETCH_BUSY = 1'b1;
    tick();
    iBP_SEARCH_VALID = 1'b1;
    iBP_SEARCH_HIT = 1'b1;
    iBP_SEARCH_PREDICT_BRANCH = 1'b1;
    iBP_SEARCH_ADDR = 32'h8000;
    tick();
    iBP_SEARCH_VALID = 1'b0;
    iBP_SEARCH_HIT = 1'b0;
    iBP_SEARCH_PREDICT_BRANCH = 1'b0;
    iBP_SEARCH_ADDR = '0;
    chk("late_req", oFETCH_REQ, 1);
    chk("late_pred", oFETCH_PREDICT, 0);
    chk("late_paddr", oFETCH_PREDICT_ADDR, 32'h0);
    iFETCH_BUSY = 1'b0;
    tick();

    // Redirect in WAIT, response two cycles later is discarded.
    chk("jw_stb", oBP_SEARCH_STB, 1);
    chk("jw_saddr", oBP_SEARCH_INST_ADDR, 32'h2008);
    tick();
    iJUMP_STB = 1'b1;
    iJUMP_ADDR = 32'h4006;
    tick();
    iJUMP_STB = 1'b0;
    chk("drain_stb", oBP_SEARCH_STB, 0);
    chk("drain_req", oFETCH_REQ, 0);
    tick();
    chk("drain2_req", oFETCH_REQ, 0);
    iBP_SEARCH_VALID = 1'b1;
    iBP_SEARCH_HIT = 1'b1;
    iBP_SEARCH_PREDICT_BRANCH = 1'b1;
    iBP_SEARCH_ADDR = 32'h9000;
    tick();
    iBP_SEARCH_VALID = 1'b0;
    iBP_SEARCH_HIT = 1'b0;
    iBP_SEARCH_PREDICT_BRANCH = 1'b0;
    iBP_SEARCH_ADDR = '0;
    chk("jw_req", oFETCH_REQ, 0);
    doSearch(32'h4004, 1, 0, 32'h7000, 0, 32'h0);

    // PC wrap at the top of the address space.
    toReq(32'h4008, 0, 0, 32'h0, 0, 32'h0);
    iJUMP_STB = 1'b1;
    iJUMP_ADDR = 32'hFFFF_FFFF;
    tick();
    iJUMP_STB = 1'b0;
    doSearch(32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0);

    // Back-to-back redirects: the last one wins.
    chk("b2b_saddr", oBP_SEARCH_INST_ADDR, 32'h0);
    iJUMP_STB = 1'b1;
    iJUMP_ADDR = 32'h500;
    tick();
    iJUMP_ADDR = 32'h600;
    tick();
    iJUMP_STB = 1'b0;
    chk("b2b_stb", oBP_SEARCH_STB, 0);
    iBP_SEARCH_VALID = 1'b1;
    tick();
    iBP_SEARCH_VALID = 1'b0;

    // Asynchronous reset in the middle of a REQ.
    toReq(32'h600, 1, 1, 32'h1234, 1, 32'h1234);
    #2 inRESET = 1'b0;
    #1;
    chk("arst_req", oFETCH_REQ, 0);
    chk("arst_faddr", oFETCH_ADDR, 32'h0);
    chk("arst_stb", oBP_SEARCH_STB, 0);
    chk("arst_saddr", oBP_SEARCH_INST_ADDR, 32'h0);
    chk("arst_pred", oFETCH_PREDICT, 0);
    chk("arst_paddr", oFETCH_PREDICT_ADDR, 32'h0);
    #2 inRESET = 1'b1;
    tick();
    chk("rerun_stb", oBP_SEARCH_STB, 1);
    chk("rerun_saddr", oBP_SEARCH_INST_ADDR, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
